// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types and constants: fetch FSM encoding, IF/ID payload, NOP encoding.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{vld: 1'b0, pc: 32'h0000_0000, instr: NOP_INSTR};

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, keeps one imem request in flight, 1 instr/cycle with 1-cycle memory.
// Decode stalls park a returned word in a one-entry hold buffer; redirects bubble IF/ID and drop stale responses.
module if_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] pc_out,
    output logic            misalign_err
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    if_id_t          r_if_id;
    if_id_t          w_if_id_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] r_hold_buf;
    logic            w_hold_load;
    logic            w_req;
    logic [XLEN-1:0] w_addr;
    logic            r_misalign;
    logic            w_misalign_nxt;

    assign w_pc_inc       = r_pc + 32'd4;
    assign w_misalign_nxt = redirect_valid & (redirect_pc[1:0] != 2'b00);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_if_id_nxt = r_if_id;
        w_hold_load = 1'b0;
        w_req       = 1'b0;
        w_addr      = r_pc;

        if (redirect_valid) begin
            // Redirect beats stall: the instruction in IF/ID is on the wrong path anyway.
            w_pc_nxt    = align_word(redirect_pc);
            w_if_id_nxt = IF_ID_BUBBLE;
            unique case (r_state)
                REQ:  w_state_nxt = REQ;
                HOLD: w_state_nxt = REQ;
                WAIT: w_state_nxt = imem_valid ? REQ : DROP;
                DROP: w_state_nxt = DROP;
            endcase
        end else begin
            unique case (r_state)
                REQ: begin
                    w_req       = 1'b1;
                    w_addr      = r_pc;
                    w_state_nxt = WAIT;
                    if (!stall) w_if_id_nxt = IF_ID_BUBBLE;
                end
                WAIT: begin
                    if (imem_valid && stall) begin
                        w_hold_load = 1'b1;
                        w_state_nxt = HOLD;
                    end else if (imem_valid) begin
                        // Back-to-back: next fetch leaves in the same cycle the word lands.
                        w_if_id_nxt = '{vld: 1'b1, pc: r_pc, instr: imem_rdata};
                        w_pc_nxt    = w_pc_inc;
                        w_req       = 1'b1;
                        w_addr      = w_pc_inc;
                    end else if (!stall) begin
                        w_if_id_nxt = IF_ID_BUBBLE;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        w_if_id_nxt = '{vld: 1'b1, pc: r_pc, instr: r_hold_buf};
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = REQ;
                    end
                end
                DROP: begin
                    if (!stall) w_if_id_nxt = IF_ID_BUBBLE;
                    if (imem_valid) w_state_nxt = REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= REQ;
            r_pc       <= RESET_PC;
            r_if_id    <= IF_ID_BUBBLE;
            r_hold_buf <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_if_id    <= w_if_id_nxt;
            r_misalign <= w_misalign_nxt;
            if (w_hold_load) r_hold_buf <= imem_rdata;
        end
    end

    assign imem_req     = w_req & reset;
    assign imem_addr    = w_addr;
    assign if_id_valid  = r_if_id.vld;
    assign if_id_pc     = r_if_id.pc;
    assign if_id_instr  = r_if_id.instr;
    assign pc_out       = r_pc;
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a variable-latency instruction memory model.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [31:0] pc_out;
    logic        misalign_err;

    int          n_checks;
    int          n_errors;
    int          lat;
    int          mem_cnt;
    logic [31:0] mem_addr;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .pc_out         (pc_out),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h8) ? 32'h0050_0093 : a;
    endfunction

    // Memory model: response at posedge+2, request sampled at posedge+3.
    initial begin
        imem_valid = 1'b0;
        imem_rdata = '0;
        mem_cnt    = 0;
        mem_addr   = '0;
        forever begin
            @(posedge clk);
            #2;
            imem_valid = 1'b0;
            imem_rdata = '0;
            if (mem_cnt == 1) begin
                imem_valid = 1'b1;
                imem_rdata = mem_data(mem_addr);
            end
            if (mem_cnt != 0) mem_cnt = mem_cnt - 1;
            #1;
            if (imem_req === 1'b1) begin
                mem_cnt  = lat;
                mem_addr = imem_addr;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        lat            = 1;

        // Reset values
        step();
        step();
        chk("rst_vld",   {31'd0, if_id_valid}, 32'd0);
        chk("rst_pc",    if_id_pc, 32'd0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_pcout", pc_out, 32'd0);
        chk("rst_mis",   {31'd0, misalign_err}, 32'd0);
        #3 chk("rst_req", {31'd0, imem_req}, 32'd0);

        // Streaming with 1-cycle memory
        step(); reset = 1'b1;
        #3 chk("s_req0", {31'd0, imem_req}, 32'd1);
        chk("s_addr0", imem_addr, 32'h0);
        step();
        #3 chk("s_addr1", imem_addr, 32'h4);
        step();
        chk("s_vld0", {31'd0, if_id_valid}, 32'd1);
        chk("s_pc0", if_id_pc, 32'h0);
        chk("s_in0", if_id_instr, 32'h0);
        chk("s_pco0", pc_out, 32'h4);
        step();
        chk("s_pc1", if_id_pc, 32'h4);
        chk("s_in1", if_id_instr, 32'h4);
        chk("s_pco1", pc_out, 32'h8);
        step();
        chk("s_pc2", if_id_pc, 32'h8);
        chk("s_in2", if_id_instr, 32'h0050_0093);
        chk("s_pco2", pc_out, 32'hC);
        step();
        chk("s_pc3", if_id_pc, 32'hC);
        chk("s_pco3", pc_out, 32'h10);

        // Stall while the word for pc=8 returns
        do_reset();
        step();
        step();
        step();
        chk("h_pc_r3", if_id_pc, 32'h4);
        stall = 1'b1;
        #3 chk("h_req_r3", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("h_pc_hold", if_id_pc, 32'h4);
            chk("h_vld_hold", {31'd0, if_id_valid}, 32'd1);
            chk("h_pco_hold", pc_out, 32'h8);
            #3 chk("h_req_hold", {31'd0, imem_req}, 32'd0);
        end
        step();
        stall = 1'b0;
        chk("h_pc_r6", if_id_pc, 32'h4);
        #3 chk("h_req_r6", {31'd0, imem_req}, 32'd0);
        step();
        chk("h_pc_out", if_id_pc, 32'h8);
        chk("h_in_out", if_id_instr, 32'h0050_0093);
        chk("h_pco_out", pc_out, 32'hC);
        #3 chk("h_req_r7", {31'd0, imem_req}, 32'd1);
        chk("h_addr_r7", imem_addr, 32'hC);
        step();
        chk("h_vld_r8", {31'd0, if_id_valid}, 32'd0);

        // Redirect with 3-cycle memory while request for 0x10 is outstanding
        do_reset();
        step();
        step();
        step();
        step();
        lat = 3;
        #3 chk("d_req10", {31'd0, imem_req}, 32'd1);
        chk("d_addr10", imem_addr, 32'h10);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #3 chk("d_req_redir", {31'd0, imem_req}, 32'd0);
        step();
        redirect_valid = 1'b0;
        chk("d_pco", pc_out, 32'h40);
        chk("d_vld_r6", {31'd0, if_id_valid}, 32'd0);
        #3 chk("d_req_r6", {31'd0, imem_req}, 32'd0);
        step();
        chk("d_vld_r7", {31'd0, if_id_valid}, 32'd0);
        #3 chk("d_req_r7", {31'd0, imem_req}, 32'd0);
        step();
        chk("d_vld_r8", {31'd0, if_id_valid}, 32'd0);
        #3 chk("d_req_r8", {31'd0, imem_req}, 32'd1);
        chk("d_addr_r8", imem_addr, 32'h40);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("d_vld_wait", {31'd0, if_id_valid}, 32'd0);
        end
        step();
        chk("d_vld_40", {31'd0, if_id_valid}, 32'd1);
        chk("d_pc_40", if_id_pc, 32'h40);
        chk("d_in_40", if_id_instr, 32'h40);
        chk("d_pco_44", pc_out, 32'h44);

        // Redirect and stall together in HOLD
        lat = 1;
        do_reset();
        step();
        step();
        stall = 1'b1;
        step();
        chk("r_vld_hold", {31'd0, if_id_valid}, 32'd1);
        chk("r_pc_hold", if_id_pc, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        #3 chk("r_req_hold", {31'd0, imem_req}, 32'd0);
        step();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        chk("r_vld", {31'd0, if_id_valid}, 32'd0);
        chk("r_instr", if_id_instr, NOP);
        chk("r_pco", pc_out, 32'h80);
        #3 chk("r_req", {31'd0, imem_req}, 32'd1);
        chk("r_addr", imem_addr, 32'h80);

        // Misaligned redirect target
        step();
        chk("m_mis_pre", {31'd0, misalign_err}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        #3 chk("m_req", {31'd0, imem_req}, 32'd0);
        step();
        redirect_valid = 1'b0;
        chk("m_pco", pc_out, 32'h40);
        chk("m_mis_on", {31'd0, misalign_err}, 32'd1);
        chk("m_vld", {31'd0, if_id_valid}, 32'd0);
        #3 chk("m_addr", imem_addr, 32'h40);
        step();
        chk("m_mis_off", {31'd0, misalign_err}, 32'd0);

        // Reset while a request is outstanding; response lands during reset
        lat = 3;
        step();
        chk("x_vld_pre", {31'd0, if_id_valid}, 32'd1);
        chk("x_pc_pre", if_id_pc, 32'h40);
        reset = 1'b0;
        step();
        chk("x_vld", {31'd0, if_id_valid}, 32'd0);
        chk("x_pc", if_id_pc, 32'h0);
        chk("x_instr", if_id_instr, NOP);
        chk("x_pco", pc_out, 32'h0);
        #3 chk("x_req9", {31'd0, imem_req}, 32'd0);
        step();
        chk("x_pco10", pc_out, 32'h0);
        #3 chk("x_req10", {31'd0, imem_req}, 32'd0);
        step();
        reset = 1'b1;
        lat   = 1;
        chk("x_vld_r0", {31'd0, if_id_valid}, 32'd0);
        #3 chk("x_req_r0", {31'd0, imem_req}, 32'd1);
        chk("x_addr_r0", imem_addr, 32'h0);

        // PC wraps past the top of the address space
        step();
        chk("w_vld_r1", {31'd0, if_id_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #3 chk("w_req_r1", {31'd0, imem_req}, 32'd0);
        step();
        redirect_valid = 1'b0;
        chk("w_pco", pc_out, 32'hFFFF_FFFC);
        #3 chk("w_addr_top", imem_addr, 32'hFFFF_FFFC);
        step();
        #3 chk("w_req_wrap", {31'd0, imem_req}, 32'd1);
        chk("w_addr_wrap", imem_addr, 32'h0);
        step();
        chk("w_vld", {31'd0, if_id_valid}, 32'd1);
        chk("w_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("w_instr", if_id_instr, 32'hFFFF_FFFC);
        chk("w_pco0", pc_out, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the decode stage and the IF/ID register. It owns the PC register and issues one-outstanding requests to a variable-latency instruction memory. It absorbs decode stalls with a one-entry hold buffer and handles EX-stage redirects (branch/jump) by injecting bubbles and discarding stale responses. It drives pc_out to the core top.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, address/instruction width (only 32 supported)

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  synchronous, active-low (0 = reset); sampled on rising clk
stall  in  1  hazard unit: hold IF/ID and PC this cycle
redirect_valid  in  1  EX-stage taken branch/jump
redirect_pc  in  32  redirect target
imem_req  out  1  fetch request strobe (combinational, one-cycle)
imem_addr  out  32  fetch address, valid when imem_req=1
imem_valid  in  1  response strobe, >=1 cycle after accepted imem_req
imem_rdata  in  32  instruction word, valid with imem_valid
if_id_valid  out  1  IF/ID register holds a real instruction
if_id_pc  out  32  PC of instruction in IF/ID
if_id_instr  out  32  instruction in IF/ID (NOP when invalid)
pc_out  out  32  current fetch PC register
misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0

Behaviour:
- Reset (reset==0 at clk edge): pc=RESET_PC, state=REQ, if_id_valid=0, if_id_pc=0, if_id_instr=32'h0000_0013, hold buffer empty, misalign_err=0. imem_req=0 while reset==0. Reset mid-request: state cleared; any response arriving during reset or in the first REQ cycle after it is ignored.
- States: REQ (no request outstanding), WAIT (one request outstanding), HOLD (response buffered, decode stalled), DROP (stale request outstanding after redirect).
- REQ: imem_req=1, imem_addr=pc, unless redirect_valid. Next state WAIT.
- WAIT, imem_valid=1, stall=0: IF/ID <= {1, pc, imem_rdata}; pc <= pc+4; imem_req=1 with imem_addr=pc+4 in the same cycle; stay WAIT. With 1-cycle memory this gives 1 instr/cycle.
- WAIT, imem_valid=1, stall=1: imem_rdata goes to the hold buffer; IF/ID and pc unchanged; go to HOLD; no request.
- WAIT, imem_valid=0: IF/ID <= bubble unless stall=1 (then hold).
- HOLD, stall=1: everything held. HOLD, stall=0: IF/ID <= {1, pc, buffer}; pc <= pc+4; go to REQ.
- Redirect has priority over stall in every state. pc <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble; imem_req forced to 0 that cycle. Next state by current state:
  - REQ: stay REQ.
  - HOLD: buffer discarded, go to REQ.
  - WAIT with imem_valid=1 same cycle: response discarded, go to REQ.
  - WAIT with imem_valid=0: go to DROP.
  - DROP: pc updated, stay DROP.
- DROP: imem_req=0; on imem_valid the response is discarded and state goes to REQ. IF/ID stays a bubble.
- misalign_err: registered; 1 for exactly one cycle after a redirect with redirect_pc[1:0]!=0.
- pc arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Never more than one outstanding request. imem_valid in REQ or HOLD is a protocol error and is ignored.

Decomposition:
- riscv_pkg: NOP_INSTR=32'h0000_0013, fetch state enum {REQ,WAIT,HOLD,DROP}, default RESET_PC.
- No sub-module required. Hold buffer and FSM stay inline; an optional if_hold_buf is allowed if it is reused by the MEM stage.

Test Plan:
- Reset then 1-cycle memory returning addr as data, no stall -> if_id_pc 0,4,8,C on consecutive cycles after 2-cycle startup; pc_out leads by 4.
- stall=1 for 3 cycles while response 0x00500093 arrives at pc=8 -> IF/ID holds pc=4 for 3 cycles, then 0x00500093/pc=8. No extra imem_req during HOLD.
- 3-cycle memory latency, redirect to 0x40 one cycle after request at pc=0x10 -> stale response discarded; next imem_addr=0x40; if_id_valid=0 until 0x40 returns.
- redirect and stall same cycle in HOLD -> buffer dropped, IF/ID bubble, next imem_addr=redirect_pc.
- redirect_pc=0x43 -> pc_out=0x40, misalign_err pulses exactly 1 cycle.
- reset asserted while in WAIT, response arrives during reset -> outputs at reset values; first post-reset imem_addr=RESET_PC.
